// File: rtl/j1_io_uart_if.sv
// ----------------------------------------------------------------------------
// j1_io_uart_if
// J1 I/O bus as seen by one memory-mapped responder.
//   io_rd   : CPU read strobe, one cycle
//   io_wr   : CPU write strobe, one cycle (also pulses for RAM stores)
//   io_addr : byte address
//   io_dout : write data from the CPU
//   io_din  : read data to the CPU, combinational from io_addr
// Handshake: there is no valid/ready pair. A transfer happens in every cycle
// where io_rd or io_wr is high; the target never stalls, so io_din must be
// valid in the same cycle and writes take effect at that cycle's clock edge.
// ----------------------------------------------------------------------------
interface j1_io_uart_if;
    logic        io_rd;
    logic        io_wr;
    logic [31:0] io_addr;
    logic [31:0] io_dout;
    logic [31:0] io_din;

    modport master (output io_rd, output io_wr, output io_addr, output io_dout,
                    input  io_din);
    modport slave  (input  io_rd, input  io_wr, input  io_addr, input  io_dout,
                    output io_din);
endinterface

// File: rtl/j1_io_uart.sv
// ----------------------------------------------------------------------------
// j1_io_uart
// Zero-wait-state UART responder on the J1 I/O bus: TX FIFO + serialiser and
// a single-entry RX holding register with sticky status flags.
// Register map (exact 32-bit address match):
//   BASE+0 DATA   W: push byte to TX FIFO   R: {24'b0, rx_data}, pops rx_valid
//   BASE+4 STATUS R: [0] tx_full [1] tx_idle [2] rx_valid [3] rx_ovr
//                    [4] frame_err [5] tx_ovf [12:8] tx_count
//                 W: 1 in bit 3/4/5 clears the matching sticky flag
//   BASE+8 BAUD   R/W [15:0], clocks per bit, writes below 4 stored as 4
// Ports:
//   sys_clk_i, sys_rst_i : clock, synchronous active-high reset
//   io                   : J1 I/O bus (slave modport)
//   uart_tx              : serial out, idle high
//   uart_rx              : serial in, asynchronous
//   o_dbg_tx_state       : current TX FSM state
//   o_dbg_rx_state       : current RX FSM state (0 when RX is not built)
// Build option: define J1_UART_RX_EN to include the receive path. Without it
// uart_rx is ignored, DATA reads 0 and STATUS bits [4:2] read 0.
// ----------------------------------------------------------------------------
module j1_io_uart #(
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
    parameter logic [15:0] BAUD_RESET = 16'd434,
    parameter int          TXF_LOG2   = 4
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    j1_io_uart_if.slave io,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic [1:0]  o_dbg_tx_state,
    output logic [2:0]  o_dbg_rx_state
);
    localparam int                DEPTH     = 1 << TXF_LOG2;
    localparam logic [TXF_LOG2:0] FULL_CNT  = (TXF_LOG2 + 1)'(DEPTH);
    localparam logic [31:0]       ADDR_STAT = BASE_ADDR + 32'd4;
    localparam logic [31:0]       ADDR_BAUD = BASE_ADDR + 32'd8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Bus decode; strobes are masked while reset is asserted.
    logic w_sel_data, w_sel_stat, w_sel_baud, w_wr, w_rd;
    logic w_wr_data, w_wr_stat, w_wr_baud, w_rd_data;
    assign w_sel_data = (io.io_addr == BASE_ADDR);
    assign w_sel_stat = (io.io_addr == ADDR_STAT);
    assign w_sel_baud = (io.io_addr == ADDR_BAUD);
    assign w_wr       = io.io_wr & ~sys_rst_i;
    assign w_rd       = io.io_rd & ~sys_rst_i;
    assign w_wr_data  = w_wr & w_sel_data;
    assign w_wr_stat  = w_wr & w_sel_stat;
    assign w_wr_baud  = w_wr & w_sel_baud;
    assign w_rd_data  = w_rd & w_sel_data;

    logic [15:0]         r_baud;
    logic [7:0]          r_mem [DEPTH];
    logic [TXF_LOG2-1:0] r_wptr, r_rptr;
    logic [TXF_LOG2:0]   r_count;
    logic                r_tx_ovf;
    logic                w_tx_full, w_push, w_pop, w_tx_idle;

    tx_state_t   r_tx_state, w_tx_state_nxt;
    logic [15:0] r_tx_bcnt,  w_tx_bcnt_nxt;
    logic [2:0]  r_tx_bit,   w_tx_bit_nxt;
    logic [7:0]  r_tx_shr,   w_tx_shr_nxt;
    logic        r_tx_line,  w_tx_line_nxt;

    logic       w_rx_valid, w_rx_ovr, w_rx_ferr;
    logic [7:0] w_rx_data;
    logic       w_unused;

    assign w_tx_full = (r_count == FULL_CNT);
    assign w_push    = w_wr_data & ~w_tx_full;
    assign w_tx_idle = (r_count == '0) && (r_tx_state == TX_IDLE);

    // TX next-state: every non-idle state lasts r_tx_bcnt+1 clocks; the
    // divisor is sampled only at reload, so a BAUD write never stretches a
    // bit already on the line. A FIFO entry is popped whenever START is entered.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_bcnt_nxt  = r_tx_bcnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shr_nxt   = r_tx_shr;
        w_tx_line_nxt  = r_tx_line;
        w_pop          = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_line_nxt = 1'b1;
                if (r_count != '0) begin
                    w_pop          = 1'b1;
                    w_tx_state_nxt = TX_START;
                    w_tx_bcnt_nxt  = r_baud - 16'd1;
                    w_tx_shr_nxt   = r_mem[r_rptr];
                    w_tx_line_nxt  = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_bcnt == 16'd0) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_bcnt_nxt  = r_baud - 16'd1;
                    w_tx_bit_nxt   = 3'd0;
                    w_tx_line_nxt  = r_tx_shr[0];
                end else begin
                    w_tx_bcnt_nxt  = r_tx_bcnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (r_tx_bcnt == 16'd0) begin
                    w_tx_bcnt_nxt = r_baud - 16'd1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = TX_STOP;
                        w_tx_line_nxt  = 1'b1;
                    end else begin
                        w_tx_bit_nxt  = r_tx_bit + 3'd1;
                        w_tx_shr_nxt  = {1'b0, r_tx_shr[7:1]};
                        w_tx_line_nxt = r_tx_shr[1];
                    end
                end else begin
                    w_tx_bcnt_nxt = r_tx_bcnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (r_tx_bcnt == 16'd0) begin
                    if (r_count != '0) begin
                        w_pop          = 1'b1;
                        w_tx_state_nxt = TX_START;
                        w_tx_bcnt_nxt  = r_baud - 16'd1;
                        w_tx_shr_nxt   = r_mem[r_rptr];
                        w_tx_line_nxt  = 1'b0;
                    end else begin
                        w_tx_state_nxt = TX_IDLE;
                        w_tx_line_nxt  = 1'b1;
                    end
                end else begin
                    w_tx_bcnt_nxt = r_tx_bcnt - 16'd1;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_baud     <= BAUD_RESET;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_tx_ovf   <= 1'b0;
            r_tx_state <= TX_IDLE;
            r_tx_bcnt  <= '0;
            r_tx_bit   <= '0;
            r_tx_shr   <= '0;
            r_tx_line  <= 1'b1;
        end else begin
            if (w_wr_baud)
                r_baud <= (io.io_dout[15:0] < 16'd4) ? 16'd4 : io.io_dout[15:0];
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr_stat && io.io_dout[5]) r_tx_ovf <= 1'b0;
            if (w_wr_data && w_tx_full)     r_tx_ovf <= 1'b1;
            r_tx_state <= w_tx_state_nxt;
            r_tx_bcnt  <= w_tx_bcnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shr   <= w_tx_shr_nxt;
            r_tx_line  <= w_tx_line_nxt;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (w_push) r_mem[r_wptr] <= io.io_dout[7:0];
    end

    assign uart_tx        = r_tx_line;
    assign o_dbg_tx_state = r_tx_state;

`ifdef J1_UART_RX_EN
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    rx_state_t   r_rx_state, w_rx_state_nxt;
    logic [15:0] r_rx_bcnt,  w_rx_bcnt_nxt;
    logic [2:0]  r_rx_bit,   w_rx_bit_nxt;
    logic [7:0]  r_rx_shr,   w_rx_shr_nxt;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid, r_rx_ovr, r_rx_ferr;
    logic        w_rx_store, w_rx_ferr_set;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_bcnt_nxt  = r_rx_bcnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shr_nxt   = r_rx_shr;
        w_rx_store     = 1'b0;
        w_rx_ferr_set  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                // Falling edge on the synchronised line; first sample is half a bit later.
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_bcnt_nxt  = {1'b0, r_baud[15:1]} - 16'd1;
                end
            end
            RX_START: begin
                if (r_rx_bcnt == 16'd0) begin
                    if (r_rx_s2) begin
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_state_nxt = RX_DATA;
                        w_rx_bcnt_nxt  = r_baud - 16'd1;
                        w_rx_bit_nxt   = 3'd0;
                    end
                end else begin
                    w_rx_bcnt_nxt = r_rx_bcnt - 16'd1;
                end
            end
            RX_DATA: begin
                if (r_rx_bcnt == 16'd0) begin
                    w_rx_shr_nxt  = {r_rx_s2, r_rx_shr[7:1]};
                    w_rx_bcnt_nxt = r_baud - 16'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
                    else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
                end else begin
                    w_rx_bcnt_nxt = r_rx_bcnt - 16'd1;
                end
            end
            RX_STOP: begin
                if (r_rx_bcnt == 16'd0) begin
                    if (r_rx_s2) begin
                        w_rx_store     = 1'b1;
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_ferr_set  = 1'b1;
                        w_rx_state_nxt = RX_WAIT;
                    end
                end else begin
                    w_rx_bcnt_nxt = r_rx_bcnt - 16'd1;
                end
            end
            RX_WAIT: begin
                // Bad stop bit: do not look for a new start until the line is idle.
                if (r_rx_s2) w_rx_state_nxt = RX_IDLE;
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_bcnt  <= '0;
            r_rx_bit   <= '0;
            r_rx_shr   <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_nxt;
            r_rx_bcnt  <= w_rx_bcnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shr   <= w_rx_shr_nxt;
            if (w_wr_stat && io.io_dout[3]) r_rx_ovr  <= 1'b0;
            if (w_wr_stat && io.io_dout[4]) r_rx_ferr <= 1'b0;
            if (w_rx_ferr_set)              r_rx_ferr <= 1'b1;
            // A pop in the same cycle as a store frees the slot for the new byte.
            if (w_rx_store) begin
                if (!r_rx_valid || w_rd_data) begin
                    r_rx_data  <= r_rx_shr;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_rx_ovr   <= 1'b1;
                end
            end else if (w_rd_data) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign w_rx_valid     = r_rx_valid;
    assign w_rx_ovr       = r_rx_ovr;
    assign w_rx_ferr      = r_rx_ferr;
    assign w_rx_data      = r_rx_data;
    assign o_dbg_rx_state = r_rx_state;
    assign w_unused       = ^io.io_dout[31:16];
`else
    assign w_rx_valid     = 1'b0;
    assign w_rx_ovr       = 1'b0;
    assign w_rx_ferr      = 1'b0;
    assign w_rx_data      = 8'h00;
    assign o_dbg_rx_state = 3'd0;
    assign w_unused       = ^{io.io_dout[31:16], uart_rx, w_rd_data};
`endif

    always_comb begin
        io.io_din = 32'h0;
        if (w_sel_data)
            io.io_din = {24'h0, w_rx_data};
        else if (w_sel_stat)
            io.io_din = {19'h0, 5'(r_count), 2'b00, r_tx_ovf, w_rx_ferr, w_rx_ovr,
                         w_rx_valid, w_tx_idle, w_tx_full};
        else if (w_sel_baud)
            io.io_din = {16'h0, r_baud};
    end
endmodule

// File: tb/tb_j1_io_uart.sv
// ----------------------------------------------------------------------------
// tb_j1_io_uart
// Directed bench for j1_io_uart: register-access vector table, exact TX
// waveform, FIFO fill/overflow with a serial-capture scoreboard, RX frames
// (when J1_UART_RX_EN is defined) and mid-frame reset.
// ----------------------------------------------------------------------------
module tb_j1_io_uart;
  localparam logic [31:0] BASE   = 32'hF000_0000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_BAUD = BASE + 32'd8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  j1_io_uart_if bus ();
  logic       uart_tx;
  logic       uart_rx;
  logic [1:0] dbg_tx_state;
  logic [2:0] dbg_rx_state;

  j1_io_uart dut (
    .sys_clk_i      (clk),
    .sys_rst_i      (rst),
    .io             (bus),
    .uart_tx        (uart_tx),
    .uart_rx        (uart_rx),
    .o_dbg_tx_state (dbg_tx_state),
    .o_dbg_rx_state (dbg_rx_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         tb_baud = 434;
  logic [7:0] mon_b;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[15];

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.io_wr = 1'b1; bus.io_addr = a; bus.io_dout = d;
    @(negedge clk);
    bus.io_wr = 1'b0;
  endtask

  task automatic io_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.io_rd = 1'b1; bus.io_addr = a;
    #1 d = bus.io_din;
    @(negedge clk);
    bus.io_rd = 1'b0;
  endtask

  task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    io_read(a, d);
    check(name, d, exp);
  endtask

  task automatic drive_rx_byte(input logic [7:0] b, input int baud, input logic stop);
    @(negedge clk); uart_rx = 1'b0;
    repeat (baud - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); uart_rx = b[i];
      repeat (baud - 1) @(negedge clk);
    end
    @(negedge clk); uart_rx = stop;
    repeat (baud - 1) @(negedge clk);
    @(negedge clk); uart_rx = 1'b1;
  endtask

  // ---------------- serial monitor (bench-side UART receiver) ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && !rst) begin
        repeat (tb_baud / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (tb_baud) @(negedge clk);
          mon_b[i] = uart_tx;
        end
        repeat (tb_baud) @(negedge clk);
        got_q.push_back(mon_b);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(60000 * 10);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] rd_val;
    logic [7:0]  e, g;
    logic        frame_bits[10];
    int          waited;
    int          lows;

    vecs[0]  = '{0, A_STAT,         32'h0,         32'h0000_0002, "rst_status"};
    vecs[1]  = '{0, A_BAUD,         32'h0,         32'd434,       "rst_baud"};
    vecs[2]  = '{0, A_DATA,         32'h0,         32'h0,         "rst_data"};
    vecs[3]  = '{0, BASE + 32'hC,   32'h0,         32'h0,         "unmapped_rd"};
    vecs[4]  = '{1, A_BAUD,         32'h2,         32'h0,         "wr_baud_2"};
    vecs[5]  = '{0, A_BAUD,         32'h0,         32'd4,         "baud_clamp"};
    vecs[6]  = '{1, A_BAUD,         32'hABCD_1234, 32'h0,         "wr_baud_big"};
    vecs[7]  = '{0, A_BAUD,         32'h0,         32'h0000_1234, "baud_mask"};
    vecs[8]  = '{1, A_BAUD,         32'h4,         32'h0,         "wr_baud_4"};
    vecs[9]  = '{0, A_BAUD,         32'h0,         32'd4,         "baud_min"};
    vecs[10] = '{1, BASE + 32'h1,   32'hFF,        32'h0,         "wr_misaligned"};
    vecs[11] = '{0, A_STAT,         32'h0,         32'h0000_0002, "misaligned_no_push"};
    vecs[12] = '{0, BASE + 32'h5,   32'h0,         32'h0,         "misaligned_rd"};
    vecs[13] = '{1, A_STAT,         32'h38,        32'h0,         "w1c_idle"};
    vecs[14] = '{0, A_STAT,         32'h0,         32'h0000_0002, "w1c_no_effect"};

    bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.io_addr = '0; bus.io_dout = '0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_line", {31'h0, uart_tx}, 32'h1);
    rst = 1'b0;

    // Register-access table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) io_write(vecs[i].addr, vecs[i].data);
      else            read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // Exact TX waveform of 0x55 at BAUD=4: start, 1,0,1,0,1,0,1,0, stop
    tb_baud = 4;
    frame_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame_bits[i + 1] = i[0] ? 1'b0 : 1'b1;
    frame_bits[9] = 1'b1;
    exp_q.push_back(8'h55);
    io_write(A_DATA, 32'h55);
    check("tx1_latency", {31'h0, uart_tx}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("tx1_bit%0d_clk%0d", k, c), {31'h0, uart_tx}, {31'h0, frame_bits[k]});
      end
    end
    read_check(A_STAT, 32'h0000_0002, "tx1_idle_after");

    // 17 back-to-back writes: the first byte moves straight into the
    // serialiser, the other 16 fill the FIFO exactly.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.io_wr = 1'b1; bus.io_addr = A_DATA; bus.io_dout = 32'h10 + i;
      exp_q.push_back(8'h10 + 8'(i));
    end
    @(negedge clk);
    bus.io_wr = 1'b0;
    read_check(A_STAT, 32'h0000_1001, "tx2_full");
    io_write(A_DATA, 32'hEE);
    read_check(A_STAT, 32'h0000_1021, "tx2_ovf");
    io_write(A_STAT, 32'h20);
    read_check(A_STAT, 32'h0000_1001, "tx2_ovf_clr");

    waited = 0;
    while (got_q.size() < exp_q.size() && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check("tx2_byte_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      check("tx_serial_byte", {24'h0, g}, {24'h0, e});
    end
    repeat (10) @(negedge clk);
    read_check(A_STAT, 32'h0000_0002, "tx2_drained");

    // Receive path
    io_write(A_BAUD, 32'd8);
    tb_baud = 8;
`ifdef J1_UART_RX_EN
    drive_rx_byte(8'hA3, 8, 1'b1);
    repeat (4) @(negedge clk);
    read_check(A_STAT, 32'h0000_0006, "rx3_valid");
    read_check(A_DATA, 32'h0000_00A3, "rx3_data");
    read_check(A_STAT, 32'h0000_0002, "rx3_popped");

    drive_rx_byte(8'h11, 8, 1'b1);
    drive_rx_byte(8'h22, 8, 1'b1);
    repeat (4) @(negedge clk);
    read_check(A_STAT, 32'h0000_000E, "rx4_ovr");
    read_check(A_DATA, 32'h0000_0011, "rx4_first_kept");
    io_write(A_STAT, 32'h08);
    read_check(A_STAT, 32'h0000_0002, "rx4_ovr_clr");

    drive_rx_byte(8'h11, 8, 1'b1);
    repeat (4) @(negedge clk);
    read_check(A_STAT, 32'h0000_0006, "rx4_held");
    // The stop bit is stored on the 79th clock edge after the start bit is
    // driven; the DATA read is lined up to pop on that same edge.
    fork
      drive_rx_byte(8'h44, 8, 1'b1);
      begin
        repeat (79) @(negedge clk);
        bus.io_rd = 1'b1; bus.io_addr = A_DATA;
        #1 rd_val = bus.io_din;
        @(negedge clk);
        bus.io_rd = 1'b0;
      end
    join
    check("rx4_pop_old", rd_val, 32'h0000_0011);
    repeat (4) @(negedge clk);
    read_check(A_STAT, 32'h0000_0006, "rx4_collide_no_ovr");
    read_check(A_DATA, 32'h0000_0044, "rx4_collide_new");

    drive_rx_byte(8'h3C, 8, 1'b0);
    repeat (6) @(negedge clk);
    read_check(A_STAT, 32'h0000_0012, "rx5_frame_err");
    io_write(A_STAT, 32'h10);
    read_check(A_STAT, 32'h0000_0002, "rx5_ferr_clr");

    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk);
    @(negedge clk); uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    read_check(A_STAT, 32'h0000_0002, "rx5_glitch_status");
    check("rx5_glitch_state", {29'h0, dbg_rx_state}, 32'h0);
`else
    drive_rx_byte(8'hA3, 8, 1'b1);
    repeat (4) @(negedge clk);
    read_check(A_STAT, 32'h0000_0002, "norx_status");
    read_check(A_DATA, 32'h0000_0000, "norx_data");
    drive_rx_byte(8'h3C, 8, 1'b0);
    repeat (6) @(negedge clk);
    read_check(A_STAT, 32'h0000_0002, "norx_no_ferr");
`endif

    // Reset during TX bit 3 of 0x00 with two more bytes queued
    io_write(A_BAUD, 32'd4);
    tb_baud = 4;
    io_write(A_DATA, 32'h00);
    io_write(A_DATA, 32'h5A);
    io_write(A_DATA, 32'h77);
    repeat (14) @(negedge clk);
    check("rst6_in_bit3", {31'h0, uart_tx}, 32'h0);
    rst = 1'b1;
    bus.io_wr = 1'b1; bus.io_addr = A_BAUD; bus.io_dout = 32'd8;
    @(negedge clk);
    check("rst6_tx_high", {31'h0, uart_tx}, 32'h1);
    @(negedge clk);
    bus.io_wr = 1'b0;
    rst = 1'b0;
    read_check(A_STAT, 32'h0000_0002, "rst6_status");
    read_check(A_BAUD, 32'd434, "rst6_baud");
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("rst6_fifo_lost", lows, 0);
    got_q.delete();

    // Unmapped and RAM stores
    io_write(BASE + 32'hC, 32'hFFFF_FFFF);
    io_write(32'h0000_0100, 32'h41);
    read_check(A_STAT, 32'h0000_0002, "unmapped_wr_status");
    read_check(A_BAUD, 32'd434, "unmapped_wr_baud");
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("unmapped_wr_no_tx", lows, 0);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
